// File: rtl/dmem_arbiter_pkg.sv
// Shared identifiers for the data-memory arbiter: requester ids, FSM encoding
// and the width of the starvation counter (holds STARVE_LIMIT up to 255).
package dmem_arbiter_pkg;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

  localparam int CNT_W = 8;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (m0, fixed priority) and the UART
// loader (m1, starvation guard + burst lock); routes 1-cycle read data back.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clka,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_nxt;
  logic             rd_pend, rd_pend_nxt;
  logic             rd_owner, rd_owner_nxt;
  logic             lock_hold;
  logic             force_m1;
  logic             gnt0, gnt1;

  // A dropped lock releases the port in the same cycle, so LOCKED only
  // constrains arbitration while m1_lock is still high.
  always_comb begin
    state_nxt = ARB;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    lock_hold = (state == LOCKED) && m1_lock;
    force_m1  = (starve_cnt == LIMIT) && m1_req;

    if (lock_hold) begin
      gnt1      = m1_req;
      state_nxt = LOCKED;
    end else begin
      if (force_m1 || (m1_req && !m0_req)) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = m0_req;
      end
      if (gnt1 && m1_lock) begin
        state_nxt = LOCKED;
      end
    end

    // Grants are combinational, so they are masked while reset is asserted.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (lock_hold || gnt1 || !m1_req) begin
      starve_nxt = '0;
    end else if (starve_cnt != LIMIT) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    rd_pend_nxt  = 1'b0;
    rd_owner_nxt = rd_owner;
    if (gnt0 && !m0_we) begin
      rd_pend_nxt  = 1'b1;
      rd_owner_nxt = M_CPU;
    end else if (gnt1 && !m1_we) begin
      rd_pend_nxt  = 1'b1;
      rd_owner_nxt = M_LDR;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= M_CPU;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      rd_pend    <= rd_pend_nxt;
      rd_owner   <= rd_owner_nxt;
    end
  end

  always_comb begin
    mem_wea   = 1'b0;
    mem_addra = '0;
    mem_dina  = '0;
    if (gnt0) begin
      mem_wea   = m0_we;
      mem_addra = m0_addr;
      mem_dina  = m0_wdata;
    end else if (gnt1) begin
      mem_wea   = m1_we;
      mem_addra = m1_addr;
      mem_dina  = m1_wdata;
    end
  end

  assign mem_ena   = gnt0 | gnt1;
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;

  assign m0_rvalid = rd_pend && (rd_owner == M_CPU);
  assign m1_rvalid = rd_pend && (rd_owner == M_LDR);
  assign m0_rdata  = mem_douta;
  assign m1_rdata  = mem_douta;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the driver queues expected grants and read
// returns, a negedge monitor pops them whenever the DUT presents gnt/rvalid.
module tb_dmem_arbiter;

  logic        clka = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ena, mem_wea;
  logic [31:0] mem_addra, mem_dina;
  logic [31:0] mem_douta = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int g0_cnt = 0;
  int g1_cnt = 0;

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } gnt_exp_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  gnt_exp_t gq[$];
  rd_exp_t  rq[$];
  logic [31:0] mem [logic [31:0]];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clka(clka), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  always #5 clka = ~clka;
  always @(posedge clka) cyc++;

  // Behavioural memory with one-cycle registered read.
  always @(posedge clka) begin
    if (mem_ena) begin
      if (mem_wea) mem[mem_addra] = mem_dina;
      else mem_douta <= mem.exists(mem_addra) ? mem[mem_addra] : 32'h0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h required %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clka) begin
    gnt_exp_t ge;
    rd_exp_t  re;
    if (rst_n) begin
      if (m0_gnt || m1_gnt) begin
        if (m0_gnt) g0_cnt++;
        if (m1_gnt) g1_cnt++;
        if (gq.size() == 0) begin
          chk("gnt_unexpected", {m0_gnt, m1_gnt, mem_addra}, 128'h0);
        end else begin
          ge = gq.pop_front();
          chk("gnt", {m0_gnt, m1_gnt, mem_ena, mem_wea, mem_addra, mem_dina, ge.cyc == cyc},
              {!ge.id, ge.id, 1'b1, ge.we, ge.addr, ge.wdata, 1'b1});
        end
      end else begin
        chk("idle_bus", {mem_ena, mem_wea, mem_addra, mem_dina}, 128'h0);
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", {m0_rvalid, m1_rvalid}, 128'h0);
        end else begin
          re = rq.pop_front();
          chk("rvalid", {m0_rvalid, m1_rvalid, (re.id ? m1_rdata : m0_rdata), re.cyc == cyc},
              {!re.id, re.id, re.data, 1'b1});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic lock);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lock;
  endtask

  task automatic exp_gnt(input logic id, input logic we, input logic [31:0] a, input logic [31:0] d);
    gq.push_back('{id: id, we: we, addr: a, wdata: d, cyc: cyc});
  endtask

  task automatic exp_rd(input logic id, input logic [31:0] data);
    rq.push_back('{id: id, data: data, cyc: cyc + 1});
  endtask

  task automatic idle();
    drv0(1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g0_base, g1_base, m0_i, n1;
    mem[32'h0080_0000] = 32'h1111_2222;

    // Reset with a live m0 request: every output must stay 0.
    rst_n = 1'b0;
    idle();
    drv0(1'b1, 1'b0, 32'h0080_0000, 32'h0);
    #1;
    chk("reset_outputs", {m0_gnt, m1_gnt, mem_ena, mem_wea, mem_addra, mem_dina, m0_rvalid, m1_rvalid},
        128'h0);
    idle();
    #12 rst_n = 1'b1;
    tick();

    // Lone m0 read: grant now, data next cycle to m0 only.
    drv0(1'b1, 1'b0, 32'h0080_0000, 32'h0);
    exp_gnt(1'b0, 1'b0, 32'h0080_0000, 32'h0);
    exp_rd(1'b0, 32'h1111_2222);
    tick();
    idle();
    tick();
    tick();

    // Both streaming writes: m1 forced on the 9th cycle of every 9.
    g0_base = g0_cnt; g1_base = g1_cnt; m0_i = 0; n1 = 0;
    for (int k = 0; k < 18; k++) begin
      drv0(1'b1, 1'b1, 32'h200 + 4 * m0_i, 32'hC0DE_0000 + m0_i);
      drv1(1'b1, 1'b1, 32'h300 + 4 * n1, 32'hB000_0000 + n1, 1'b0);
      if (k % 9 == 8) begin
        exp_gnt(1'b1, 1'b1, 32'h300 + 4 * n1, 32'hB000_0000 + n1);
        n1++;
      end else begin
        exp_gnt(1'b0, 1'b1, 32'h200 + 4 * m0_i, 32'hC0DE_0000 + m0_i);
        m0_i++;
      end
      tick();
    end
    chk("starve_share_m1", g1_cnt - g1_base, 2);
    chk("starve_share_m0", g0_cnt - g0_base, 16);
    idle();
    tick();

    // Locked burst: m1 owns the port while m0 waits; dropping lock hands it back.
    drv1(1'b1, 1'b1, 32'h0080_0004, 32'hDEAD_BEEF, 1'b1);
    exp_gnt(1'b1, 1'b1, 32'h0080_0004, 32'hDEAD_BEEF);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drv0(1'b1, 1'b0, 32'h0080_0004, 32'h0);
      drv1(1'b1, 1'b1, 32'h0080_0004 + 4 * i, 32'hA000_0000 + i, 1'b1);
      exp_gnt(1'b1, 1'b1, 32'h0080_0004 + 4 * i, 32'hA000_0000 + i);
      tick();
    end
    drv1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_gnt(1'b0, 1'b0, 32'h0080_0004, 32'h0);
    exp_rd(1'b0, 32'hDEAD_BEEF);
    tick();
    idle();
    tick();

    // Alternating reads: each return goes to its own requester.
    drv0(1'b1, 1'b0, 32'h0080_0000, 32'h0);
    exp_gnt(1'b0, 1'b0, 32'h0080_0000, 32'h0);
    exp_rd(1'b0, 32'h1111_2222);
    tick();
    drv0(1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b1, 1'b0, 32'h0080_0008, 32'h0, 1'b0);
    exp_gnt(1'b1, 1'b0, 32'h0080_0008, 32'h0);
    exp_rd(1'b1, 32'hA000_0001);
    tick();
    idle();
    tick();
    tick();

    // Lock without grant has no effect: m0 keeps winning.
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b1, 32'h400 + 4 * i, 32'h5A5A_0000 + i);
      drv1(i == 2, 1'b0, 32'h0080_0000, 32'h0, 1'b1);
      exp_gnt(1'b0, 1'b1, 32'h400 + 4 * i, 32'h5A5A_0000 + i);
      tick();
    end
    idle();
    tick();

    // Reset mid-read after building up starvation count.
    for (int i = 0; i < 3; i++) begin
      drv0(1'b1, 1'b1, 32'h500 + 4 * i, 32'h7700_0000 + i);
      drv1(1'b1, 1'b0, 32'h0080_0000, 32'h0, 1'b0);
      exp_gnt(1'b0, 1'b1, 32'h500 + 4 * i, 32'h7700_0000 + i);
      tick();
    end
    drv0(1'b1, 1'b0, 32'h0080_0004, 32'h0);
    exp_gnt(1'b0, 1'b0, 32'h0080_0004, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midread_reset_outputs",
        {m0_gnt, m1_gnt, mem_ena, mem_wea, mem_addra, mem_dina, m0_rvalid, m1_rvalid}, 128'h0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    chk("no_rvalid_after_reset", {m0_rvalid, m1_rvalid}, 128'h0);
    tick();
    g1_base = g1_cnt;
    for (int k = 0; k < 9; k++) begin
      drv0(1'b1, 1'b1, 32'h600 + 4 * k, 32'h6600_0000 + k);
      drv1(1'b1, 1'b1, 32'h700, 32'hBEEF_0001, 1'b0);
      if (k == 8) exp_gnt(1'b1, 1'b1, 32'h700, 32'hBEEF_0001);
      else exp_gnt(1'b0, 1'b1, 32'h600 + 4 * k, 32'h6600_0000 + k);
      tick();
    end
    chk("post_reset_starve_count", g1_cnt - g1_base, 1);
    idle();
    tick();
    tick();
    tick();

    chk("gnt_queue_drained", gq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
